// File: rtl/dcf77_pulse_decoder.sv
// DCF77 front end: classifies second-mark pulses against a 1 ms timebase and assembles 59-bit minute frames.
// Optional 8-sample ms-rate glitch filter on the synchronized input is enabled by defining DCF77_GLITCH_FILTER_EN.
module dcf77_pulse_decoder #(
    parameter int CLOCK_FREQUENCY = 16000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcf_in,
    output logic [58:0] dcf_bits,
    output logic        dcf_new_sec,
    output logic        dcf_sec_tick,
    output logic        dcf_synced
);

    localparam int MS_DIV = CLOCK_FREQUENCY / 1000;
    localparam int PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);

    localparam logic [1:0] ST_UNSYNC     = 2'd0;
    localparam logic [1:0] ST_WAIT_PULSE = 2'd1;
    localparam logic [1:0] ST_PULSE      = 2'd2;
    localparam logic [1:0] ST_ERROR      = 2'd3;

    localparam logic [11:0] SAT_MAX = 12'hFFF;

    logic        r_sync1;
    logic        r_sync2;
    logic [PW-1:0] r_presc;
    logic        r_dcf_prev;
    logic [11:0] r_pulse_ms;
    logic [11:0] r_gap_ms;
    logic [1:0]  r_state;
    logic [5:0]  r_bit_cnt;
    logic [58:0] r_shift;
    logic [58:0] r_dcf_bits;
    logic        r_new_sec;
    logic        r_sec_tick;
    logic        r_synced;

    logic        w_ms_tick;
    logic        w_dcf_s;
    logic        w_rise;
    logic        w_fall;
    logic        w_glitch;
    logic [11:0] w_pulse_base;
    logic [11:0] w_gap_base;
    logic [11:0] w_pulse_next;
    logic [11:0] w_gap_next;
    logic        w_gap_1500;
    logic        w_gap_2500;
    logic        w_pulse_1000;
    logic        w_is_zero;
    logic        w_is_one;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= dcf_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ms_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_ms_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

`ifdef DCF77_GLITCH_FILTER_EN
    logic [7:0] r_filt_sh;
    logic       r_filt_out;
    logic [7:0] w_filt_next;

    assign w_filt_next = {r_filt_sh[6:0], r_sync2};

    // Output only flips once eight consecutive ms samples agree.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_filt_sh  <= '0;
            r_filt_out <= 1'b0;
        end else if (w_ms_tick) begin
            r_filt_sh <= w_filt_next;
            if (&w_filt_next) begin
                r_filt_out <= 1'b1;
            end else if (~|w_filt_next) begin
                r_filt_out <= 1'b0;
            end
        end
    end

    assign w_dcf_s = r_filt_out;
`else
    assign w_dcf_s = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dcf_prev <= 1'b0;
        end else begin
            r_dcf_prev <= w_dcf_s;
        end
    end

    assign w_rise = w_dcf_s & ~r_dcf_prev;
    assign w_fall = ~w_dcf_s & r_dcf_prev;

    // A rejected short pulse must not restart the gap measurement.
    assign w_glitch = (r_state == ST_PULSE) & w_fall & (r_pulse_ms < 12'd40);

    assign w_pulse_base = w_rise ? 12'd0 : r_pulse_ms;
    assign w_gap_base   = (w_fall & ~w_glitch) ? 12'd0 : r_gap_ms;

    assign w_pulse_next = (w_ms_tick & w_dcf_s & (w_pulse_base != SAT_MAX))
                          ? w_pulse_base + 12'd1 : w_pulse_base;
    assign w_gap_next   = (w_ms_tick & ~w_dcf_s & (w_gap_base != SAT_MAX))
                          ? w_gap_base + 12'd1 : w_gap_base;

    // Threshold events fire on the tick that moves the counter onto the threshold.
    assign w_gap_1500   = w_ms_tick & ~w_dcf_s & (w_gap_base == 12'd1499);
    assign w_gap_2500   = w_ms_tick & ~w_dcf_s & (w_gap_base == 12'd2499);
    assign w_pulse_1000 = w_ms_tick & w_dcf_s & (w_pulse_base == 12'd999);

    assign w_is_zero = (r_pulse_ms >= 12'd40)  && (r_pulse_ms <= 12'd149);
    assign w_is_one  = (r_pulse_ms >= 12'd150) && (r_pulse_ms <= 12'd250);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pulse_ms <= '0;
            r_gap_ms   <= '0;
        end else begin
            r_pulse_ms <= w_pulse_next;
            r_gap_ms   <= w_gap_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_UNSYNC;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dcf_bits <= '0;
            r_new_sec  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_synced   <= 1'b0;
        end else begin
            r_new_sec  <= 1'b0;
            r_sec_tick <= 1'b0;
            case (r_state)
                ST_UNSYNC, ST_ERROR: begin
                    if (w_gap_1500) begin
                        r_state   <= ST_WAIT_PULSE;
                        r_synced  <= 1'b1;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                ST_WAIT_PULSE: begin
                    if (w_gap_1500) begin
                        if (r_bit_cnt == 6'd59) begin
                            r_dcf_bits <= r_shift;
                            r_new_sec  <= 1'b1;
                        end
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        if (w_rise) begin
                            r_state <= ST_PULSE;
                        end
                    end else if (w_gap_2500) begin
                        r_state  <= ST_UNSYNC;
                        r_synced <= 1'b0;
                    end else if (w_rise) begin
                        r_state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (w_fall) begin
                        if (r_pulse_ms < 12'd40) begin
                            r_state <= ST_WAIT_PULSE;
                        end else if ((w_is_zero || w_is_one) && (r_bit_cnt != 6'd59)) begin
                            r_shift    <= {w_is_one, r_shift[58:1]};
                            r_bit_cnt  <= r_bit_cnt + 6'd1;
                            r_sec_tick <= 1'b1;
                            r_state    <= ST_WAIT_PULSE;
                        end else begin
                            // Over-long pulse or a 60th bit (leap-second frame).
                            r_state   <= ST_ERROR;
                            r_synced  <= 1'b0;
                            r_bit_cnt <= '0;
                        end
                    end else if (w_pulse_1000) begin
                        r_state   <= ST_ERROR;
                        r_synced  <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                default: r_state <= ST_UNSYNC;
            endcase
        end
    end

    assign dcf_bits     = r_dcf_bits;
    assign dcf_new_sec  = r_new_sec;
    assign dcf_sec_tick = r_sec_tick;
    assign dcf_synced   = r_synced;

endmodule

// File: tb/tb_dcf77_pulse_decoder.sv
// Scoreboard bench for dcf77_pulse_decoder at 1 clk per ms; frames use compressed bit spacing to stay short.
`timescale 1ns/1ps
module tb_dcf77_pulse_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dcf_in = 1'b0;
    logic [58:0] dcf_bits;
    logic        dcf_new_sec;
    logic        dcf_sec_tick;
    logic        dcf_synced;

    int checks = 0;
    int failures = 0;
    int tick_seen = 0;
    logic [58:0] exp_q[$];

    localparam logic [58:0] PAT_A = 59'h2AAAAAAAAAAAAAA;
    localparam logic [58:0] PAT_B = 59'h4D213579BDF0246;

    always #5 clk = ~clk;

    dcf77_pulse_decoder #(.CLOCK_FREQUENCY(1000)) dut (
        .clk         (clk),
        .reset       (reset),
        .dcf_in      (dcf_in),
        .dcf_bits    (dcf_bits),
        .dcf_new_sec (dcf_new_sec),
        .dcf_sec_tick(dcf_sec_tick),
        .dcf_synced  (dcf_synced)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Widths rotate through the classification boundaries.
    function automatic int width_of(input logic b, input int i);
        case (i % 3)
            0:       return b ? 150 : 40;
            1:       return b ? 200 : 100;
            default: return b ? 250 : 149;
        endcase
    endfunction

    // Monitor: pops expected frames whenever the DUT strobes dcf_new_sec.
    initial begin
        bit ns_prev;
        logic [58:0] exp;
        ns_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (dcf_sec_tick) tick_seen++;
            if (ns_prev) begin
                checks++;
                if (dcf_new_sec) begin
                    failures++;
                    $display("FAIL new_sec_width actual=1 required=0");
                end
            end
            if (dcf_new_sec) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_new_sec actual_bits=%0h required=no_strobe", dcf_bits);
                end else begin
                    exp = exp_q.pop_front();
                    if (dcf_bits !== exp) begin
                        failures++;
                        $display("FAIL frame_bits actual=%0h required=%0h", dcf_bits, exp);
                    end else begin
                        $display("ok   frame_bits value=%0h", dcf_bits);
                    end
                end
            end
            ns_prev = dcf_new_sec;
        end
    end

    // Sends nbits pulses; returns 1502 cycles after the last falling edge of dcf_in.
    task automatic send_frame(input logic [63:0] bits, input int nbits, input int err_idx,
                              input int spike_idx, input bit accept, input int exp_ticks,
                              input string tag);
        int t0;
        int w;
        t0 = tick_seen;
        if (accept) exp_q.push_back(bits[58:0]);
        for (int i = 0; i < nbits; i++) begin
            w = (i == err_idx) ? 251 : width_of(bits[i], i);
            dcf_in = 1'b1;
            wait_cyc(w);
            dcf_in = 1'b0;
            if (i < nbits - 1) begin
                if (i == err_idx) begin
                    wait_cyc(5);
                    check({tag, "_synced_drop"}, 64'(dcf_synced), 64'd0);
                    wait_cyc(35);
                end else if (i == spike_idx) begin
                    wait_cyc(40);
                    dcf_in = 1'b1;
                    wait_cyc(39);
                    dcf_in = 1'b0;
                    wait_cyc(61);
                end else begin
                    wait_cyc(40);
                end
            end
        end
        wait_cyc(5);
        if (nbits == 60) check({tag, "_overflow_drop"}, 64'(dcf_synced), 64'd0);
        wait_cyc(1496);
        check({tag, "_new_sec_early"}, 64'(dcf_new_sec), 64'd0);
        wait_cyc(1);
        check({tag, "_new_sec_at_marker"}, 64'(dcf_new_sec), 64'(accept));
        check({tag, "_synced_after_marker"}, 64'(dcf_synced), 64'd1);
        check({tag, "_tick_count"}, 64'(tick_seen - t0), 64'(exp_ticks));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) begin
            @(negedge clk);
            dcf_in = ~dcf_in;
        end
        @(negedge clk);
        dcf_in = 1'b0;
        check("reset_bits", 64'(dcf_bits), 64'd0);
        check("reset_new_sec", 64'(dcf_new_sec), 64'd0);
        check("reset_sec_tick", 64'(dcf_sec_tick), 64'd0);
        check("reset_synced", 64'(dcf_synced), 64'd0);
        reset = 1'b1;

        wait_cyc(1499);
        check("sync_before_1500", 64'(dcf_synced), 64'd0);
        wait_cyc(1);
        check("sync_at_1500", 64'(dcf_synced), 64'd1);
        wait_cyc(500);

        send_frame({5'd0, PAT_B}, 58, -1, -1, 1'b0, 58, "f58");
        wait_cyc(200);
        send_frame({5'd0, PAT_A}, 59, -1, 10, 1'b1, 59, "fA_spike");
        wait_cyc(200);
        send_frame({5'd0, PAT_A}, 59, 30, -1, 1'b0, 30, "ferr");
        check("bits_kept_after_err", 64'(dcf_bits), 64'(PAT_A));
        wait_cyc(200);
        send_frame({4'd0, 1'b1, PAT_B}, 60, -1, -1, 1'b0, 59, "f60");
        check("bits_kept_after_overflow", 64'(dcf_bits), 64'(PAT_A));
        wait_cyc(200);
        send_frame({5'd0, PAT_B}, 59, -1, -1, 1'b1, 59, "fB");

        wait_cyc(999);
        check("timeout_before_2500", 64'(dcf_synced), 64'd1);
        wait_cyc(1);
        check("timeout_at_2500", 64'(dcf_synced), 64'd0);
        wait_cyc(500);
        check("bits_held_after_timeout", 64'(dcf_bits), 64'(PAT_B));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
